max_calc_arbiter: RTL and testbench
===================================

Name: max_calc_arbiter

Overview:
Shares one pipelined max(arg0 ± arg1, arg2 ± arg3) datapath between N_REQ requesters in the SISO decoder, e.g. the alpha, beta and LLR metric units.
- Round-robin grant, one operation issued per cycle.
- Requester id is tagged through the 2-stage pipe.
- Results are buffered in a credit-protected response FIFO, so downstream backpressure never drops a result.

Parameters:
DWIDTH, 16, operand/result width (unsigned)
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equal to clog2(N_REQ)
RSP_DEPTH, 4, response FIFO depth and credit count (power of 2, >= 2)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
i_req_valid  in  N_REQ  per-requester request valid
o_req_ready  out  N_REQ  per-requester grant; one-hot or zero
i_req_args  in  N_REQ*4*DWIDTH  per requester {arg3,arg2,arg1,arg0}; requester k occupies slice [k*4*DWIDTH +: 4*DWIDTH]
i_req_op  in  N_REQ*2  per requester {op23,op01}; 0 = add, 1 = subtract
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accept
o_rsp_id  out  ID_W  requester that issued the result
o_rsp_data  out  DWIDTH  max result

Behaviour:
- Reset: aclk and areset only; reset is synchronous, active-high.
  - All outputs go to 0; the pipe and the FIFO are flushed.
  - Credits are set to RSP_DEPTH and the RR pointer to 0.
  - Reset mid-operation discards all in-flight results; no response is emitted for them.
- Grant:
  - o_req_ready[k] = 1 only when credits > 0 and k is the first valid requester at or after the RR pointer, searching upward with wrap.
  - o_req_ready is combinational from i_req_valid, the pointer and credits.
  - A handshake is i_req_valid[k] & o_req_ready[k] at a rising edge.
  - After a grant to k, the pointer becomes (k+1) mod N_REQ. With no grant, the pointer holds.
- Credits:
  - Decrement on grant; increment on response handshake (o_rsp_valid & i_rsp_ready).
  - Both in the same cycle leaves credits unchanged.
  - Credits never exceed RSP_DEPTH or drop below 0. At credits == 0, all o_req_ready bits are 0.
- Datapath (pipe stages):
  - Stage 1 registers, at the grant edge E0:
    - s01 = arg0 ± arg1
    - s23 = arg2 ± arg3
    - Both are DWIDTH+1 bit; subtract wraps modulo 2^(DWIDTH+1).
  - Stage 2 registers at E1: if s01 > s23 (unsigned, DWIDTH+1 bit) then s01[DWIDTH-1:0], else s23[DWIDTH-1:0]. A tie selects s23.
  - The id and a valid bit travel with the data through both stages.
- Latency:
  - The result is written to the FIFO at E2.
  - If the FIFO was empty, o_rsp_valid is high in the cycle after E2, i.e. 3 cycles after the grant.
  - Responses come out in grant order.
- FIFO:
  - Show-ahead; o_rsp_id and o_rsp_data hold stable while o_rsp_valid = 1 and i_rsp_ready = 0.
  - A simultaneous write and read while full cannot occur; the credit scheme guarantees it.
  - Read and write pointers wrap modulo RSP_DEPTH.
- Throughput: one grant per cycle when i_rsp_ready is held high and RSP_DEPTH >= 4.

Optional Feature:
MAX_CALC_ARB_STATS_EN:
- When defined, adds output o_stall_cnt (16 bit). It counts cycles with |i_req_valid = 1 and no grant.
  - Saturates at 0xFFFF.
  - Cleared by areset.
- When not defined, the port and its counter do not exist; grant/response behaviour is identical.

Decomposition:
- Package max_calc_pkg holds:
  - OP_ADD = 1'b0, OP_SUB = 1'b1
  - function clog2
  - the request-slice index helper
- One sub-module, max_calc_pipe: the 2-stage datapath with runtime op bits and an id/valid sideband.
- Arbiter, credit counter and FIFO stay in the top module.

Test Plan:
1. Single request: req0 args {arg0=10, arg1=5, arg2=3, arg3=4}, op=00 → 15 vs 7 gives o_rsp_data=15, id=0, o_rsp_valid exactly 3 cycles after grant.
2. Subtract and tie: op01=1, op23=0, args {9,2,3,4} → 7 vs 7 selects s23, data=7. Then args {2,3,0,0} with op01=1 → s01 wraps to 0x1FFFF > 0, data=0xFFFF.
3. Round robin: all N_REQ=4 valid continuously → grants in order 0,1,2,3,0,…, one per cycle, responses in the same id order.
4. Backpressure: i_rsp_ready=0 with req0 held valid → exactly 4 grants, then ready stays 0. Raise i_rsp_ready → 4 responses in order, grants resume as credits return.
5. Reset mid-flight: areset asserted 1 cycle after 2 grants → no responses, credits back to 4, pointer 0, next grant goes to lowest valid id.
6. With MAX_CALC_ARB_STATS_EN: hold i_rsp_ready=0 and a requester valid for 10 cycles beyond credit exhaustion → o_stall_cnt=10.

Source files
------------

// File: rtl/max_calc_pkg.sv
// rtl/max_calc_pkg.sv - shared op encodings and sizing helpers for the max-calc arbiter
// Purpose: op-bit encodings, a ceiling-log2 helper for derived widths, and the
//          bit offset of one requester's {arg3,arg2,arg1,arg0} slice.
// Ports:   none (package).
package max_calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // LSB of requester k's operand group in the flattened request bus.
  function automatic int req_slice_lsb(input int k, input int dwidth);
    return k * 4 * dwidth;
  endfunction

endpackage

// File: rtl/max_calc_pipe.sv
// rtl/max_calc_pipe.sv - two-stage max(arg0 +/- arg1, arg2 +/- arg3) datapath
// Purpose: stage 1 forms both DWIDTH+1 bit sums/differences, stage 2 keeps the
//          larger (ties pick s23); id and valid ride alongside the data.
// Ports:   clk_i, rst_i          clock, synchronous active-high reset
//          in_valid_i, in_id_i   issue strobe and requester id
//          in_args_i, in_op_i    {arg3,arg2,arg1,arg0}, {op23,op01}
//          out_valid_o, out_id_o, out_data_o   result two edges after issue
module max_calc_pipe
  import max_calc_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int ID_W   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [ID_W-1:0]       in_id_i,
  input  logic [4*DWIDTH-1:0]   in_args_i,
  input  logic [1:0]            in_op_i,
  output logic                  out_valid_o,
  output logic [ID_W-1:0]       out_id_o,
  output logic [DWIDTH-1:0]     out_data_o
);

  logic [DWIDTH:0]   arg0, arg1, arg2, arg3;
  logic [DWIDTH:0]   s01_d, s23_d, s01_q, s23_q;
  logic [DWIDTH-1:0] max_d, max_q;
  logic              v1_q, v2_q;
  logic [ID_W-1:0]   id1_q, id2_q;

  // Zero-extend so subtraction wraps modulo 2^(DWIDTH+1).
  assign arg0 = {1'b0, in_args_i[0*DWIDTH +: DWIDTH]};
  assign arg1 = {1'b0, in_args_i[1*DWIDTH +: DWIDTH]};
  assign arg2 = {1'b0, in_args_i[2*DWIDTH +: DWIDTH]};
  assign arg3 = {1'b0, in_args_i[3*DWIDTH +: DWIDTH]};

  assign s01_d = (in_op_i[0] == OP_ADD) ? arg0 + arg1 : arg0 - arg1;
  assign s23_d = (in_op_i[1] == OP_SUB) ? arg2 - arg3 : arg2 + arg3;

  // Strict compare on the full DWIDTH+1 bits, so a tie falls to s23.
  assign max_d = (s01_q > s23_q) ? s01_q[DWIDTH-1:0] : s23_q[DWIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      id1_q <= '0;
      s01_q <= '0;
      s23_q <= '0;
      v2_q  <= 1'b0;
      id2_q <= '0;
      max_q <= '0;
    end else begin
      v1_q  <= in_valid_i;
      id1_q <= in_id_i;
      s01_q <= s01_d;
      s23_q <= s23_d;
      v2_q  <= v1_q;
      id2_q <= id1_q;
      max_q <= max_d;
    end
  end

  assign out_valid_o = v2_q;
  assign out_id_o    = id2_q;
  assign out_data_o  = max_q;

endmodule

// File: rtl/max_calc_arbiter.sv
// rtl/max_calc_arbiter.sv - round-robin shared max-calc datapath with credit-protected response FIFO
// Purpose: grants one requester per cycle round-robin, pushes its operands
//          through max_calc_pipe, and buffers tagged results in a show-ahead
//          FIFO whose slots are reserved by credits at grant time.
// Ports:   aclk, areset                 clock, synchronous active-high reset
//          i_req_valid, o_req_ready     per-requester request / one-hot grant
//          i_req_args, i_req_op         per-requester operands and op bits
//          o_rsp_valid, i_rsp_ready     response handshake
//          o_rsp_id, o_rsp_data         issuing requester and max result
//          o_stall_cnt                  only with MAX_CALC_ARB_STATS_EN: saturating
//                                       count of cycles with a request but no grant
module max_calc_arbiter
  import max_calc_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ*4*DWIDTH-1:0]   i_req_args,
  input  logic [N_REQ*2-1:0]          i_req_op,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [ID_W-1:0]             o_rsp_id,
  output logic [DWIDTH-1:0]           o_rsp_data
`ifdef MAX_CALC_ARB_STATS_EN
  ,
  output logic [15:0]                 o_stall_cnt
`endif
);

  localparam int AW = clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ID_W:0]   N_REQ_W      = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID      = ID_W'(N_REQ - 1);
  localparam logic [CW-1:0]   FULL_CREDITS = CW'(RSP_DEPTH);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]        credits_q, credits_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [2*N_REQ-1:0]   req_dbl;
  logic [N_REQ-1:0]     req_rot;
  logic [ID_W:0]        rot_off, gnt_sum;
  logic [ID_W-1:0]      gnt_id;
  logic                 found, issue, rsp_hs;
  logic [4*DWIDTH-1:0]  sel_args;
  logic [1:0]           sel_op;
  logic                 pipe_valid;
  logic [ID_W-1:0]      pipe_id;
  logic [DWIDTH-1:0]    pipe_data;
  logic [ID_W+DWIDTH-1:0] mem_q [RSP_DEPTH];

  // Rotate the valids so bit 0 is the requester at the RR pointer; the
  // lowest set bit of the rotated vector is then the winner.
  assign req_dbl = {i_req_valid, i_req_valid};
  assign req_rot = req_dbl[{1'b0, ptr_q} +: N_REQ];

  always_comb begin
    rot_off = '0;
    found   = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        rot_off = (ID_W+1)'(j);
        found   = 1'b1;
      end
    end
    gnt_sum = {1'b0, ptr_q} + rot_off;
    if (gnt_sum >= N_REQ_W) gnt_sum = gnt_sum - N_REQ_W;
  end

  assign gnt_id      = gnt_sum[ID_W-1:0];
  assign issue       = found && (credits_q != '0);
  assign o_req_ready = issue ? (N_REQ'(1) << gnt_id) : '0;
  assign rsp_hs      = o_rsp_valid && i_rsp_ready;

  always_comb begin
    sel_args = '0;
    sel_op   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_req_ready[k]) begin
        sel_args = i_req_args[req_slice_lsb(k, DWIDTH) +: 4*DWIDTH];
        sel_op   = i_req_op[2*k +: 2];
      end
    end
  end

  // A credit stands for one FIFO slot, claimed at grant and freed when the
  // result leaves, so results in the pipe always have a slot waiting.
  always_comb begin
    credits_d = credits_q;
    if (issue && !rsp_hs)      credits_d = credits_q - CW'(1);
    else if (!issue && rsp_hs) credits_d = credits_q + CW'(1);

    count_d = count_q;
    if (pipe_valid && !rsp_hs)      count_d = count_q + CW'(1);
    else if (!pipe_valid && rsp_hs) count_d = count_q - CW'(1);

    ptr_d = ptr_q;
    if (issue) ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
  end

  max_calc_pipe #(
    .DWIDTH (DWIDTH),
    .ID_W   (ID_W)
  ) u_pipe (
    .clk_i       (aclk),
    .rst_i       (areset),
    .in_valid_i  (issue),
    .in_id_i     (gnt_id),
    .in_args_i   (sel_args),
    .in_op_i     (sel_op),
    .out_valid_o (pipe_valid),
    .out_id_o    (pipe_id),
    .out_data_o  (pipe_data)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr_q     <= '0;
      credits_q <= FULL_CREDITS;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      if (pipe_valid) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rsp_hs)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && pipe_valid) mem_q[wr_ptr_q] <= {pipe_id, pipe_data};
  end

  // Show-ahead head; forced to zero when empty so stale slots never leak out.
  assign o_rsp_valid            = (count_q != '0);
  assign {o_rsp_id, o_rsp_data} = o_rsp_valid ? mem_q[rd_ptr_q] : '0;

`ifdef MAX_CALC_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|i_req_valid && !issue && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_max_calc_arbiter.sv
// tb/tb_max_calc_arbiter.sv - scoreboard bench for max_calc_arbiter
module tb_max_calc_arbiter;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int D   = 4;

  logic               aclk = 1'b0;
  logic               areset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*4*DW-1:0]  req_args;
  logic [N*2-1:0]     req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
`ifdef MAX_CALC_ARB_STATS_EN
  logic [15:0]        stall_cnt;
`endif

  max_calc_arbiter #(
    .DWIDTH(DW), .N_REQ(N), .ID_W(IDW), .RSP_DEPTH(D)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_args  (req_args),
    .i_req_op    (req_op),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data)
`ifdef MAX_CALC_ARB_STATS_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int     id;
    int     data;
    longint avail;
  } exp_t;

  exp_t   exp_q[$];
  int     gnt_log[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     m_ptr = 0;
  int     m_credits = D;
  int     n_grants = 0;
  int     n_rsp = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: the larger of the two wrapped (DW+1)-bit results, low DW bits kept.
  function automatic int model_max(input int a0, input int a1, input int a2, input int a3,
                                   input logic [1:0] op);
    int m, s01, s23;
    m   = (1 << (DW + 1)) - 1;
    s01 = (op[0] ? a0 - a1 : a0 + a1) & m;
    s23 = (op[1] ? a2 - a3 : a2 + a3) & m;
    return ((s01 > s23) ? s01 : s23) & ((1 << DW) - 1);
  endfunction

  // Monitor: predicts grants from an RR pointer and credit count, pushes the
  // expected result on every predicted grant, pops and compares on responses.
  logic [N-1:0] exp_rdy;
  logic         exp_v;
  int           g, kk, res;
  int           a[4];
  logic [1:0]   op;

  always @(negedge aclk) begin
    if (areset) begin
      exp_q.delete();
      m_ptr     = 0;
      m_credits = D;
    end else begin
      exp_v = 1'b0;
      if (exp_q.size() != 0) exp_v = (exp_q[0].avail <= cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
      end

      g = -1;
      if (m_credits > 0) begin
        for (int i = 0; i < N; i++) begin
          kk = (m_ptr + i) % N;
          if (g < 0 && 1'(req_valid >> kk)) g = kk;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));

      if (exp_v && rsp_ready) begin
        void'(exp_q.pop_front());
        m_credits++;
        n_rsp++;
      end
      if (g >= 0) begin
        for (int j = 0; j < 4; j++) a[j] = int'(DW'(req_args >> (4*DW*g + DW*j)));
        op  = 2'(req_op >> (2*g));
        res = model_max(a[0], a[1], a[2], a[3], op);
        exp_q.push_back('{id: g, data: res, avail: cyc + 3});
        m_ptr = (g + 1) % N;
        m_credits--;
        n_grants++;
        gnt_log.push_back(g);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    req_valid = '0;
    step(1);
    @(negedge aclk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge aclk);
      if (rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic single(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                        input logic [15:0] a3, input logic [1:0] o, input logic [15:0] want,
                        input string name);
    int lat;
    req_args[4*DW-1:0] = {a3, a2, a1, a0};
    req_op[1:0]        = o;
    req_valid          = 4'b0001;
    @(negedge aclk);
    chk({name, "_grant"}, 64'(req_ready), 64'(4'b0001));
    @(posedge aclk);
    #1;
    req_valid = '0;
    wait_rsp(lat);
    chk({name, "_latency"}, 64'(lat), 64'(3));
    chk({name, "_data"}, 64'(rsp_data), 64'(want));
    chk({name, "_id"}, 64'(rsp_id), 64'(0));
    step(2);
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1);
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    areset    = 1'b1;
    req_valid = '0;
    req_args  = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Single request, add/add, then subtract with tie and subtract wrap.
    single(16'd10, 16'd5, 16'd3, 16'd4, 2'b00, 16'd15,   "t1_add");
    single(16'd9,  16'd2, 16'd3, 16'd4, 2'b01, 16'd7,    "t2_tie");
    single(16'd2,  16'd3, 16'd0, 16'd0, 2'b01, 16'hFFFF, "t2_wrap");

    // Round robin with all requesters valid.
    do_reset();
    req_args  = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
    req_op    = 8'($urandom());
    gnt_log.delete();
    req_valid = 4'hF;
    step(12);
    req_valid = '0;
    chk("rr_count", 64'(gnt_log.size()), 64'(12));
    for (int i = 0; i < 12 && i < gnt_log.size(); i++)
      chk("rr_order", 64'(gnt_log[i]), 64'(i % N));
    drain("rr_drain");

    // Backpressure: credits cap outstanding grants at the FIFO depth.
    do_reset();
    rsp_ready = 1'b0;
    n_grants  = 0;
    n_rsp     = 0;
    req_valid = 4'b0001;
    step(10);
    chk("bp_grants", 64'(n_grants), 64'(D));
    @(negedge aclk);
    chk("bp_ready_zero", 64'(req_ready), 64'(0));
    @(posedge aclk);
    #1;
    rsp_ready = 1'b1;
    step(10);
    chk("bp_resume", 64'(n_grants > D), 64'(1));
    chk("bp_rsp", 64'(n_rsp >= D), 64'(1));
    drain("bp_drain");

    // Reset one cycle after two grants discards them and restores the pointer.
    do_reset();
    req_valid = 4'b0011;
    step(2);
    req_valid = '0;
    areset    = 1'b1;
    step(1);
    areset    = 1'b0;
    n_before  = n_rsp;
    req_valid = 4'b0110;
    @(negedge aclk);
    chk("rst_next_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge aclk);
    #1;
    req_valid = '0;
    step(8);
    chk("rst_rsp_count", 64'(n_rsp - n_before), 64'(1));

`ifdef MAX_CALC_ARB_STATS_EN
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step(14);
    @(negedge aclk);
    chk("stall_cnt", 64'(stall_cnt), 64'(10));
    @(posedge aclk);
    #1;
    drain("stall_drain");
`endif

    // Randomised traffic with phases of heavy and light backpressure.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom());
      req_args  = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) req_args = req_args & {64{4'h3}};
      req_op    = 8'($urandom());
      if (((c / 200) % 2) == 1) rsp_ready = ($urandom_range(0, 3) == 0);
      else                      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
